// File: rtl/osecpu_seq_if.sv
// Bus between the OSECPU sequencer, program memory and the integer register file.
// The master side is the sequencer; the slave side is memory plus register file.
interface osecpu_seq_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int REG_AW = 6
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic [31:0]       mem_rdata;
    logic [REG_AW-1:0] ireg_r0;
    logic [REG_AW-1:0] ireg_r1;
    logic [DATA_W-1:0] ireg_d0;
    logic [DATA_W-1:0] ireg_d1;
    logic [REG_AW-1:0] ireg_rw;
    logic [DATA_W-1:0] ireg_dw;
    logic              ireg_we;

    modport master (
        output mem_req, mem_addr, ireg_r0, ireg_r1, ireg_rw, ireg_dw, ireg_we,
        input  mem_valid, mem_rdata, ireg_d0, ireg_d1
    );

    modport slave (
        input  mem_req, mem_addr, ireg_r0, ireg_r1, ireg_rw, ireg_dw, ireg_we,
        output mem_valid, mem_rdata, ireg_d0, ireg_d1
    );
endinterface

// File: rtl/osecpu_seq.sv
// OSECPU instruction sequencer: FETCH/EXEC/HALT loop over a req/valid memory port.
// Define OSECPU_SEQ_BRANCH_EN to enable opcode 0x04 (CND, conditional skip of next word).
module osecpu_seq #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int REG_AW = 6
) (
    input  logic              clk,
    input  logic              reset,
    osecpu_seq_if.master      bus,
    output logic [ADDR_W-1:0] pc,
    output logic [7:0]        cur_op,
    output logic              halted,
    output logic              err
);
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LIMM  = 8'h02;
    localparam logic [7:0] OP_PLIMM = 8'h03;
    localparam logic [7:0] OP_OR    = 8'h10;
    localparam logic [7:0] OP_XOR   = 8'h11;
    localparam logic [7:0] OP_AND   = 8'h12;
    localparam logic [7:0] OP_ADD   = 8'h14;
    localparam logic [7:0] OP_SUB   = 8'h15;
    localparam logic [7:0] OP_CP    = 8'hD2;
    localparam logic [7:0] OP_HALT  = 8'hFF;
`ifdef OSECPU_SEQ_BRANCH_EN
    localparam logic [7:0] OP_CND   = 8'h04;
`endif

    state_t                   r_state, w_state_nxt;
    logic [ADDR_W-1:0]        r_pc, w_pc_nxt;
    logic [31:0]              r_instr, w_instr_nxt;
    logic                     r_err, w_err_nxt;
    logic [7:0]               w_op;
    logic [REG_AW-1:0]        w_o0, w_o1, w_o2;
    logic [REG_AW-1:0]        w_r0, w_r1, w_rw;
    logic signed [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0]        w_dw;
    logic                     w_we;
    logic                     w_skip;
    logic                     w_unused;
`ifdef OSECPU_SEQ_BRANCH_EN
    logic                     r_skip, w_skip_nxt;
    assign w_skip = r_skip;
`else
    assign w_skip = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] f_alu(input logic [7:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        case (op)
            OP_OR:   f_alu = a | b;
            OP_XOR:  f_alu = a ^ b;
            OP_AND:  f_alu = a & b;
            OP_ADD:  f_alu = a + b;
            OP_SUB:  f_alu = a - b;
            default: f_alu = '0;
        endcase
    endfunction

    assign w_op     = r_instr[31:24];
    assign w_o0     = REG_AW'(r_instr[23:18]);
    assign w_o1     = REG_AW'(r_instr[17:12]);
    assign w_o2     = REG_AW'(r_instr[11:6]);
    assign w_imm    = {{(DATA_W-16){r_instr[15]}}, r_instr[15:0]};
    assign w_unused = ^r_instr[5:0];

    // Read addresses depend only on latched state so the external file's comb read never loops back.
    always_comb begin
        w_r0 = '0;
        w_r1 = '0;
        if (r_state == S_EXEC && !w_skip) begin
            case (w_op)
                OP_CP: w_r0 = w_o1;
                OP_OR, OP_XOR, OP_AND, OP_ADD, OP_SUB: begin
                    w_r0 = w_o1;
                    w_r1 = w_o2;
                end
`ifdef OSECPU_SEQ_BRANCH_EN
                OP_CND: w_r0 = w_o0;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_err_nxt   = r_err;
        w_rw        = '0;
        w_dw        = '0;
        w_we        = 1'b0;
`ifdef OSECPU_SEQ_BRANCH_EN
        w_skip_nxt  = r_skip;
`endif
        case (r_state)
            S_FETCH: begin
                if (bus.mem_valid) begin
                    w_instr_nxt = bus.mem_rdata;
                    w_pc_nxt    = r_pc + 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_FETCH;
                if (w_skip) begin
`ifdef OSECPU_SEQ_BRANCH_EN
                    w_skip_nxt = 1'b0;
`endif
                end else begin
                    case (w_op)
                        OP_NOP: ;
                        OP_LIMM: begin
                            w_rw = w_o0;
                            w_dw = w_imm;
                            w_we = 1'b1;
                        end
                        OP_PLIMM: w_pc_nxt = w_imm[ADDR_W-1:0];
                        OP_CP: begin
                            w_rw = w_o0;
                            w_dw = bus.ireg_d0;
                            w_we = 1'b1;
                        end
                        OP_OR, OP_XOR, OP_AND, OP_ADD, OP_SUB: begin
                            w_rw = w_o0;
                            w_dw = f_alu(w_op, bus.ireg_d0, bus.ireg_d1);
                            w_we = 1'b1;
                        end
`ifdef OSECPU_SEQ_BRANCH_EN
                        OP_CND: begin
                            if (!bus.ireg_d0[0]) w_skip_nxt = 1'b1;
                        end
`endif
                        OP_HALT: w_state_nxt = S_HALT;
                        default: begin
                            w_state_nxt = S_HALT;
                            w_err_nxt   = 1'b1;
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_instr <= '0;
            r_err   <= 1'b0;
`ifdef OSECPU_SEQ_BRANCH_EN
            r_skip  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_err   <= w_err_nxt;
`ifdef OSECPU_SEQ_BRANCH_EN
            r_skip  <= w_skip_nxt;
`endif
        end
    end

    assign bus.mem_req  = reset && (r_state == S_FETCH);
    assign bus.mem_addr = r_pc;
    assign bus.ireg_r0  = w_r0;
    assign bus.ireg_r1  = w_r1;
    assign bus.ireg_rw  = w_rw;
    assign bus.ireg_dw  = w_dw;
    assign bus.ireg_we  = w_we && reset;
    assign pc           = r_pc;
    assign cur_op       = r_instr[31:24];
    assign halted       = (r_state == S_HALT);
    assign err          = r_err;
endmodule

// File: tb/tb_osecpu_seq.sv
// Bench for osecpu_seq: program memory with configurable wait states, integer register file,
// and an instruction-level interpreter used as the reference.
module tb_osecpu_seq;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int REG_AW = 6;

    logic clk = 1'b0;
    logic reset;
    logic [ADDR_W-1:0] pc;
    logic [7:0] cur_op;
    logic halted, err;

    always #5 clk = ~clk;

    osecpu_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

    osecpu_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .pc(pc), .cur_op(cur_op), .halted(halted), .err(err)
    );

    logic [31:0] mem [0:65535];
    logic [31:0] regs [0:63];
    int   lat = 0;
    int   wcnt = 0;
    logic force_valid = 1'b0;
    logic clr = 1'b1;

    assign bus.mem_valid = (bus.mem_req && (wcnt >= lat)) || force_valid;
    assign bus.mem_rdata = mem[bus.mem_addr];
    assign bus.ireg_d0   = regs[bus.ireg_r0];
    assign bus.ireg_d1   = regs[bus.ireg_r1];

    always @(posedge clk) wcnt <= (bus.mem_req && !bus.mem_valid) ? wcnt + 1 : 0;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 64; i++) regs[i] <= '0;
        end else if (bus.ireg_we) begin
            regs[bus.ireg_rw] <= bus.ireg_dw;
        end
    end

    int   we_count = 0;
    int   stab_err = 0;
    logic prev_wait = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    int   fetch_log [$];

    always @(posedge clk) begin
        if (bus.ireg_we) we_count <= we_count + 1;
        if (reset && bus.mem_req && bus.mem_valid) fetch_log.push_back(int'(bus.mem_addr));
        if (prev_wait && bus.mem_req && (bus.mem_addr !== prev_addr)) stab_err <= stab_err + 1;
        prev_wait <= reset && bus.mem_req && !bus.mem_valid;
        prev_addr <= bus.mem_addr;
    end

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [31:0] f_enc(input logic [7:0] op, input int a, input int b, input int c);
        f_enc = {op, 6'(a), 6'(b), 6'(c), 6'b0};
    endfunction

    function automatic logic [31:0] f_limm(input int r, input logic [15:0] imm);
        f_limm = {8'h02, 6'(r), 2'b00, imm};
    endfunction

    // Reference interpreter: one loop iteration per fetched word.
    logic [31:0] mregs [0:63];
    int   m_pc, m_steps, m_writes;
    logic m_halt, m_err;

    function automatic void model_run();
        int p;
        bit skip;
        logic [31:0] w, a, b, imm;
        int o0, o1, o2;
        p = 0;
        skip = 0;
        for (int i = 0; i < 64; i++) mregs[i] = '0;
        m_halt = 0; m_err = 0; m_steps = 0; m_writes = 0;
        while (!m_halt && m_steps < 500) begin
            w = mem[p];
            p = (p + 1) % 65536;
            m_steps++;
            if (skip) begin
                skip = 0;
                continue;
            end
            o0  = int'(w[23:18]);
            o1  = int'(w[17:12]);
            o2  = int'(w[11:6]);
            imm = {{16{w[15]}}, w[15:0]};
            a   = mregs[o1];
            b   = mregs[o2];
            case (w[31:24])
                8'h00: ;
                8'h02: begin mregs[o0] = imm;   m_writes++; end
                8'h03: p = int'(imm[15:0]);
                8'hD2: begin mregs[o0] = a;     m_writes++; end
                8'h10: begin mregs[o0] = a | b; m_writes++; end
                8'h11: begin mregs[o0] = a ^ b; m_writes++; end
                8'h12: begin mregs[o0] = a & b; m_writes++; end
                8'h14: begin mregs[o0] = a + b; m_writes++; end
                8'h15: begin mregs[o0] = a - b; m_writes++; end
`ifdef OSECPU_SEQ_BRANCH_EN
                8'h04: if (mregs[o0][0] == 1'b0) skip = 1;
`endif
                8'hFF: m_halt = 1;
                default: begin m_halt = 1; m_err = 1; end
            endcase
        end
        m_pc = p;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = '0;
    endtask

    task automatic load_prog1();
        clear_mem();
        mem[0] = f_limm(1, 16'h0005);
        mem[1] = f_limm(2, 16'hFFFF);
        mem[2] = f_enc(8'h14, 3, 1, 2);
        mem[3] = 32'hFF00_0000;
    endtask

    // Reset (clearing the register file), release, then count cycles until halted.
    task automatic run_prog(input int l, output int cyc);
        lat = l;
        force_valid = 1'b0;
        reset = 1'b0;
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        reset = 1'b1;
        cyc = 0;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (halted) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clr = 1'b1;
        clear_mem();
        repeat (2) @(negedge clk);
        vectors++; if (pc !== 16'h0) begin miscompares++; $display("FAIL rst_pc got %h exp 0000", pc); end
        vectors++; if (cur_op !== 8'h00) begin miscompares++; $display("FAIL rst_op got %h exp 00", cur_op); end
        vectors++; if ({halted, err} !== 2'b00) begin miscompares++; $display("FAIL rst_flags got %b exp 00", {halted, err}); end
        vectors++; if ({bus.mem_req, bus.ireg_we} !== 2'b00) begin miscompares++; $display("FAIL rst_req_we got %b exp 00", {bus.mem_req, bus.ireg_we}); end
        lat = 2;
        clr = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        vectors++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 16'h0}) begin miscompares++; $display("FAIL rst_first_fetch got %b/%h exp 1/0000", bus.mem_req, bus.mem_addr); end
    endtask

    task automatic test_zero_wait();
        int cyc;
        load_prog1();
        run_prog(0, cyc);
        vectors++; if (cyc !== 8) begin miscompares++; $display("FAIL zw_cycles got %0d exp 8", cyc); end
        vectors++; if (regs[3] !== 32'd4) begin miscompares++; $display("FAIL zw_r3 got %h exp 00000004", regs[3]); end
        vectors++; if (regs[2] !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL zw_r2 got %h exp ffffffff", regs[2]); end
        vectors++; if ({halted, err} !== 2'b10) begin miscompares++; $display("FAIL zw_flags got %b exp 10", {halted, err}); end
        vectors++; if (pc !== 16'd4) begin miscompares++; $display("FAIL zw_pc got %h exp 0004", pc); end
        vectors++; if (cur_op !== 8'hFF) begin miscompares++; $display("FAIL zw_curop got %h exp ff", cur_op); end
    endtask

    task automatic test_wait_states();
        int cyc, s0;
        load_prog1();
        s0 = stab_err;
        run_prog(3, cyc);
        vectors++; if (cyc !== 20) begin miscompares++; $display("FAIL ws_cycles got %0d exp 20", cyc); end
        vectors++; if (regs[3] !== 32'd4) begin miscompares++; $display("FAIL ws_r3 got %h exp 00000004", regs[3]); end
        vectors++; if (stab_err - s0 !== 0) begin miscompares++; $display("FAIL ws_addr_stable got %0d changes exp 0", stab_err - s0); end
    endtask

    task automatic test_jump_wrap();
        int cyc, base;
        int exp_log [5];
        exp_log = '{0, 1, 2, 16, 65535};
        clear_mem();
        mem[2]     = 32'h0300_0010;
        mem[16]    = 32'h0300_FFFF;
        mem[65535] = 32'hFF00_0000;
        base = fetch_log.size();
        run_prog(1, cyc);
        vectors++; if (cyc !== 15) begin miscompares++; $display("FAIL jw_cycles got %0d exp 15", cyc); end
        vectors++; if (fetch_log.size() - base !== 5) begin miscompares++; $display("FAIL jw_nfetch got %0d exp 5", fetch_log.size() - base); end
        for (int i = 0; i < 5; i++) begin
            if (base + i < fetch_log.size()) begin
                vectors++;
                if (fetch_log[base + i] !== exp_log[i]) begin
                    miscompares++; $display("FAIL jw_addr%0d got %h exp %h", i, fetch_log[base + i], exp_log[i]);
                end
            end
        end
        vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL jw_pc_wrap got %h exp 0000", pc); end
        vectors++; if ({halted, err} !== 2'b10) begin miscompares++; $display("FAIL jw_flags got %b exp 10", {halted, err}); end
    endtask

    task automatic test_undefined();
        int cyc, w0, req_hi;
        clear_mem();
        mem[0] = 32'h7712_3456;
        w0 = we_count;
        run_prog(0, cyc);
        vectors++; if ({halted, err} !== 2'b11) begin miscompares++; $display("FAIL ud_flags got %b exp 11", {halted, err}); end
        vectors++; if (cyc !== 2) begin miscompares++; $display("FAIL ud_cycles got %0d exp 2", cyc); end
        req_hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.mem_req) req_hi++;
        end
        vectors++; if (req_hi !== 0) begin miscompares++; $display("FAIL ud_req_after_halt got %0d exp 0", req_hi); end
        vectors++; if (we_count - w0 !== 0) begin miscompares++; $display("FAIL ud_writes got %0d exp 0", we_count - w0); end
        vectors++; if ({pc, cur_op} !== {16'd1, 8'h77}) begin miscompares++; $display("FAIL ud_pc_op got %h/%h exp 0001/77", pc, cur_op); end
    endtask

    task automatic test_reset_mid_fetch();
        int cyc;
        load_prog1();
        lat = 3;
        reset = 1'b0;
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 16'h0}) begin miscompares++; $display("FAIL rm_waiting got %b/%h exp 1/0000", bus.mem_req, bus.mem_addr); end
        reset = 1'b0;
        @(negedge clk);
        force_valid = 1'b1;
        @(negedge clk);
        force_valid = 1'b0;
        vectors++; if ({pc, cur_op} !== {16'h0, 8'h00}) begin miscompares++; $display("FAIL rm_no_capture got %h/%h exp 0000/00", pc, cur_op); end
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rm_req_in_reset got %b exp 0", bus.mem_req); end
        reset = 1'b1;
        cyc = 0;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (halted) break;
        end
        vectors++; if (cyc !== 20) begin miscompares++; $display("FAIL rm_cycles got %0d exp 20", cyc); end
        vectors++; if (regs[3] !== 32'd4) begin miscompares++; $display("FAIL rm_r3 got %h exp 00000004", regs[3]); end
    endtask

    task automatic test_branch();
        int cyc;
        clear_mem();
        mem[0] = f_limm(5, 16'h0000);
        mem[1] = f_limm(6, 16'h0009);
        mem[2] = f_enc(8'h04, 5, 0, 0);
        mem[3] = f_limm(6, 16'h0001);
        mem[4] = f_limm(7, 16'h0002);
        mem[5] = 32'hFF00_0000;
        run_prog(0, cyc);
`ifdef OSECPU_SEQ_BRANCH_EN
        vectors++; if ({halted, err} !== 2'b10) begin miscompares++; $display("FAIL br_flags got %b exp 10", {halted, err}); end
        vectors++; if (regs[6] !== 32'd9) begin miscompares++; $display("FAIL br_r6 got %h exp 00000009", regs[6]); end
        vectors++; if (regs[7] !== 32'd2) begin miscompares++; $display("FAIL br_r7 got %h exp 00000002", regs[7]); end
        vectors++; if (pc !== 16'd6) begin miscompares++; $display("FAIL br_pc got %h exp 0006", pc); end
`else
        vectors++; if ({halted, err} !== 2'b11) begin miscompares++; $display("FAIL br_flags got %b exp 11", {halted, err}); end
        vectors++; if (regs[6] !== 32'd9) begin miscompares++; $display("FAIL br_r6 got %h exp 00000009", regs[6]); end
        vectors++; if (regs[7] !== 32'd0) begin miscompares++; $display("FAIL br_r7 got %h exp 00000000", regs[7]); end
        vectors++; if (pc !== 16'd3) begin miscompares++; $display("FAIL br_pc got %h exp 0003", pc); end
`endif
    endtask

    task automatic test_random();
        logic [7:0] ops [8];
        int cyc, len, l, w0;
        logic [7:0] op;
        ops = '{8'h00, 8'h02, 8'hD2, 8'h10, 8'h11, 8'h12, 8'h14, 8'h15};
        for (int t = 0; t < 10; t++) begin
            clear_mem();
            len = $urandom_range(4, 12);
            for (int i = 0; i < len; i++) begin
                op = ops[$urandom_range(0, 7)];
`ifdef OSECPU_SEQ_BRANCH_EN
                if ($urandom_range(0, 5) == 0) op = 8'h04;
`endif
                if (op == 8'h02)
                    mem[i] = f_limm($urandom_range(0, 7), 16'($urandom()));
                else
                    mem[i] = f_enc(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            end
            mem[len]     = ($urandom_range(0, 3) == 0) ? 32'h3000_0000 : 32'hFF00_0000;
            mem[len + 1] = 32'hFF00_0000;
            model_run();
            l = $urandom_range(0, 3);
            w0 = we_count;
            run_prog(l, cyc);
            vectors++; if (cyc !== m_steps * (l + 2)) begin miscompares++; $display("FAIL rnd%0d_cycles got %0d exp %0d", t, cyc, m_steps * (l + 2)); end
            vectors++; if ({halted, err} !== {m_halt, m_err}) begin miscompares++; $display("FAIL rnd%0d_flags got %b exp %b", t, {halted, err}, {m_halt, m_err}); end
            vectors++; if (int'(pc) !== m_pc) begin miscompares++; $display("FAIL rnd%0d_pc got %0d exp %0d", t, pc, m_pc); end
            vectors++; if (we_count - w0 !== m_writes) begin miscompares++; $display("FAIL rnd%0d_writes got %0d exp %0d", t, we_count - w0, m_writes); end
            for (int r = 0; r < 8; r++) begin
                vectors++;
                if (regs[r] !== mregs[r]) begin
                    miscompares++; $display("FAIL rnd%0d_r%0d got %h exp %h", t, r, regs[r], mregs[r]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_jump_wrap();
        test_undefined();
        test_reset_mid_fetch();
        test_branch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
